queue_tracker: RTL and testbench



---
 rtl/qm_pkg.sv | 18 +
 rtl/photo_debounce.sv | 72 +++++++
 rtl/queue_tracker.sv | 87 ++++++++
 tb/tb_queue_tracker.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/qm_pkg.sv
// Shared constants and types for the QueueManager front end.
package qm_pkg;

  localparam int PCOUNT_W = 3;
  localparam int TCOUNT_W = 2;
  localparam int ADDR_W   = TCOUNT_W + PCOUNT_W;

  localparam logic [PCOUNT_W-1:0] PCOUNT_MAX = 3'd7;

  // Debounce counter is sized for the largest supported debounce length (15).
  localparam int DEB_CNT_W = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    BLOCKED = 1'b1
  } beam_state_e;

endpackage : qm_pkg

// File: rtl/photo_debounce.sv
// Photocell beam qualifier: 2-flop synchroniser, debounce counter and a
// two-state FSM that emits a one-cycle event when a qualified block is released.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | beam clear, or blocked for fewer than DEB synchronised cycles
//   BLOCKED | beam blocked for at least DEB cycles; release emits an event
module photo_debounce
  import qm_pkg::*;
#(
  parameter int unsigned DEB = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic photo,
  output logic photo_event
);

  localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEB - 1);

  logic                 s1_q, s2_q;
  beam_state_e          state_q, state_d;
  logic [DEB_CNT_W-1:0] cnt_q, cnt_d;
  logic                 event_q, event_d;

  // Next-state logic: count consecutive synchronised-high cycles while idle,
  // and count the person only on release of a qualified block.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    event_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          if (cnt_q == DEB_LAST) begin
            state_d = BLOCKED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + DEB_CNT_W'(1);
          end
        end
      end
      BLOCKED: begin
        if (!s2_q) begin
          state_d = IDLE;
          event_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Synchroniser, FSM state, counter and registered event output.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      event_q <= 1'b0;
    end else begin
      s1_q    <= photo;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      event_q <= event_d;
    end
  end

  assign photo_event = event_q;

endmodule : photo_debounce

// File: rtl/queue_tracker.sv
// Queue occupancy tracker: counts people entering (back beam) and leaving
// (front beam), and forms the wait-time ROM address plus status flags.
module queue_tracker
  import qm_pkg::*;
#(
  parameter int unsigned DEB = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Bphoto,
  input  logic                Fphoto,
  input  logic [TCOUNT_W-1:0] Tcount,
  output logic [PCOUNT_W-1:0] Pcount,
  output logic [ADDR_W-1:0]   address,
  output logic                full,
  output logic                empty,
  output logic                upd,
  output logic                alarm
);

  logic                entry_evt, exit_evt;
  logic [PCOUNT_W-1:0] pcount_q, pcount_d;
  logic                upd_q, upd_d;
  logic                alarm_q, alarm_d;

  photo_debounce #(.DEB(DEB)) u_back (
    .clk         (clk),
    .rst         (rst),
    .photo       (Bphoto),
    .photo_event (entry_evt)
  );

  photo_debounce #(.DEB(DEB)) u_front (
    .clk         (clk),
    .rst         (rst),
    .photo       (Fphoto),
    .photo_event (exit_evt)
  );

  // Occupancy update; simultaneous entry and exit cancel out, and
  // overflow/underflow attempts hold the count and latch the alarm.
  always_comb begin
    pcount_d = pcount_q;
    upd_d    = 1'b0;
    alarm_d  = alarm_q;
    case ({entry_evt, exit_evt})
      2'b10: begin
        if (pcount_q != PCOUNT_MAX) begin
          pcount_d = pcount_q + PCOUNT_W'(1);
          upd_d    = 1'b1;
        end else begin
          alarm_d = 1'b1;
        end
      end
      2'b01: begin
        if (pcount_q != '0) begin
          pcount_d = pcount_q - PCOUNT_W'(1);
          upd_d    = 1'b1;
        end else begin
          alarm_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Count, update pulse and sticky alarm registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcount_q <= '0;
      upd_q    <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      pcount_q <= pcount_d;
      upd_q    <= upd_d;
      alarm_q  <= alarm_d;
    end
  end

  assign Pcount  = pcount_q;
  assign address = {Tcount, pcount_q};
  assign full    = (pcount_q == PCOUNT_MAX);
  assign empty   = (pcount_q == '0);
  assign upd     = upd_q;
  assign alarm   = alarm_q;

endmodule : queue_tracker

// File: tb/tb_queue_tracker.sv
// Directed bench for queue_tracker with a scoreboard of expected upd pulses.
module tb_queue_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Bphoto = 1'b0;
  logic       Fphoto = 1'b0;
  logic [1:0] Tcount = 2'd2;
  logic [2:0] Pcount;
  logic [4:0] address;
  logic       full, empty, upd, alarm;

  queue_tracker #(.DEB(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .Bphoto  (Bphoto),
    .Fphoto  (Fphoto),
    .Tcount  (Tcount),
    .Pcount  (Pcount),
    .address (address),
    .full    (full),
    .empty   (empty),
    .upd     (upd),
    .alarm   (alarm)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] p;
    int         at;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the selected beam(s) high for hi cycles, then release.
  // exp_next < 0 means no upd pulse is expected for this pass.
  task automatic beam_pass(input bit b, input bit f, input int hi, input int exp_next);
    exp_t e;
    Bphoto = b;
    Fphoto = f;
    repeat (hi) tick();
    Bphoto = 1'b0;
    Fphoto = 1'b0;
    if (exp_next >= 0) begin
      e.p  = 3'(exp_next);
      e.at = cyc + 4;
      sb.push_back(e);
    end
    repeat (7) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Monitor: every upd pulse must match the oldest expected update.
  always @(negedge clk) begin
    if (!rst && upd === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_upd: got upd=1 with Pcount=%0d, required no update (cycle %0d)", Pcount, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("upd_latency", 32'(cyc), 32'(e.at));
        check("pcount_on_upd", 32'(Pcount), 32'(e.p));
        check("address_on_upd", 32'(address), 32'({Tcount, e.p}));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_pcount", 32'(Pcount), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_upd", 32'(upd), 0);
    check("rst_alarm", 32'(alarm), 0);

    // Three entry passes with two tellers open.
    beam_pass(1, 0, 6, 1);
    beam_pass(1, 0, 6, 2);
    beam_pass(1, 0, 6, 3);
    check("three_entries_pcount", 32'(Pcount), 3);
    check("three_entries_address", 32'(address), 32'(5'b10011));
    Tcount = 2'd3;
    #1;
    check("tcount3_address", 32'(address), 32'(5'b11011));
    Tcount = 2'd0;
    #1;
    check("tcount0_address", 32'(address), 32'(5'b00011));
    Tcount = 2'd2;

    // Short glitch does not qualify.
    beam_pass(1, 0, 3, -1);
    check("glitch_pcount", 32'(Pcount), 3);

    // Saturation at 7, then one exit.
    do_reset();
    for (int i = 1; i <= 7; i++) beam_pass(1, 0, 6, i);
    check("sat_pcount7", 32'(Pcount), 7);
    check("sat_full", 32'(full), 1);
    check("sat_alarm_before", 32'(alarm), 0);
    beam_pass(1, 0, 6, -1);
    check("sat_pcount_hold", 32'(Pcount), 7);
    check("sat_alarm_set", 32'(alarm), 1);
    beam_pass(0, 1, 6, 6);
    check("sat_exit_pcount", 32'(Pcount), 6);
    check("sat_exit_full", 32'(full), 0);
    check("sat_alarm_sticky", 32'(alarm), 1);

    // Exit from empty.
    do_reset();
    check("rst_clears_alarm", 32'(alarm), 0);
    beam_pass(0, 1, 6, -1);
    check("underflow_pcount", 32'(Pcount), 0);
    check("underflow_empty", 32'(empty), 1);
    check("underflow_alarm", 32'(alarm), 1);

    // Simultaneous entry and exit cancel.
    do_reset();
    for (int i = 1; i <= 4; i++) beam_pass(1, 0, 6, i);
    beam_pass(1, 1, 6, -1);
    check("both_pcount", 32'(Pcount), 4);
    check("both_alarm", 32'(alarm), 0);

    // Reset while a beam is held blocked.
    beam_pass(1, 0, 6, 5);
    check("pre_rst_pcount", 32'(Pcount), 5);
    Bphoto = 1'b1;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_pcount", 32'(Pcount), 0);
    check("midrst_empty", 32'(empty), 1);
    tick();
    tick();
    Bphoto = 1'b0;
    repeat (8) tick();
    check("post_rst_short_pcount", 32'(Pcount), 0);
    beam_pass(1, 0, 6, 1);
    check("post_rst_full_pcount", 32'(Pcount), 1);
    check("post_rst_alarm", 32'(alarm), 0);

    repeat (4) tick();
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_queue_tracker
